// File: rtl/enemy_shot_scheduler_pkg.sv
// Shared game definitions for the enemy shot scheduler.
// Holds the scheduler state encoding and timing defaults.
package enemy_shot_scheduler_pkg;

  localparam int DEFAULT_COOLDOWN = 25000000;
  localparam int COORD_W          = 10;

  typedef enum logic [2:0] {
    ST_COOLDOWN,
    ST_SCAN,
    ST_FIRE,
    ST_WAIT_ACK,
    ST_WAIT_DONE
  } shot_state_e;

endpackage

// File: rtl/enemy_shot_scheduler.sv
// Round-robin enemy shooter: picks the next live enemy after a cooldown
// and launches the single shared enemy ball from below it.
module enemy_shot_scheduler
  import enemy_shot_scheduler_pkg::*;
#(
  parameter int SIZE_ENEMY      = 10,
  parameter int COOLDOWN_CYCLES = DEFAULT_COOLDOWN,
  localparam int AW = (SIZE_ENEMY > 1) ? $clog2(SIZE_ENEMY) : 1,
  localparam int CW = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          pausa,
  input  logic                          reiniciarJogo,
  input  logic [SIZE_ENEMY-1:0]         vivo,
  input  logic [COORD_W*SIZE_ENEMY-1:0] x_inimigo,
  input  logic [COORD_W*SIZE_ENEMY-1:0] y_inimigo,
  input  logic [COORD_W-1:0]            largura_inimigo,
  input  logic [COORD_W-1:0]            altura_inimigo,
  input  logic                          bola_ativa,
  output logic                          disparar,
  output logic [COORD_W-1:0]            xi_bola,
  output logic [COORD_W-1:0]            yi_bola,
  output logic [AW-1:0]                 atirador,
  output logic                          nenhum_vivo
);

  localparam logic [CW-1:0] CNT_INIT = CW'(COOLDOWN_CYCLES - 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(SIZE_ENEMY - 1);

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] i);
    return (i == PTR_LAST) ? '0 : i + 1'b1;
  endfunction

  shot_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [AW-1:0]        dead_q, dead_d;
  logic [COORD_W-1:0]   xi_q, xi_d;
  logic [COORD_W-1:0]   yi_q, yi_d;
  logic [AW-1:0]        shooter_q, shooter_d;
  logic                 none_q, none_d;
  logic [COORD_W-1:0]   x_sel, y_sel;

  assign x_sel = x_inimigo[COORD_W*int'(ptr_q) +: COORD_W];
  assign y_sel = y_inimigo[COORD_W*int'(ptr_q) +: COORD_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    dead_d    = dead_q;
    xi_d      = xi_q;
    yi_d      = yi_q;
    shooter_d = shooter_q;
    none_d    = none_q;
    if (reiniciarJogo) begin
      state_d   = ST_COOLDOWN;
      cnt_d     = CNT_INIT;
      ptr_d     = PTR_LAST;
      idx_d     = '0;
      dead_d    = '0;
      xi_d      = '0;
      yi_d      = '0;
      shooter_d = '0;
      none_d    = 1'b0;
    end else if (!pausa) begin
      unique case (state_q)
        ST_COOLDOWN: begin
          if (cnt_q == '0) begin
            state_d = ST_SCAN;
            idx_d   = nxt(ptr_q);
            dead_d  = '0;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        ST_SCAN: begin
          if (vivo[idx_q]) begin
            ptr_d   = idx_q;
            none_d  = 1'b0;
            state_d = ST_FIRE;
          end else if (dead_q == PTR_LAST) begin
            // Whole ring dead: keep ptr so rotation resumes where it left off.
            none_d  = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = ST_COOLDOWN;
          end else begin
            idx_d  = nxt(idx_q);
            dead_d = dead_q + 1'b1;
          end
        end
        ST_FIRE: begin
          shooter_d = ptr_q;
          xi_d      = x_sel + (largura_inimigo >> 1);
          yi_d      = y_sel + altura_inimigo;
          state_d   = ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (bola_ativa) state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!bola_ativa) begin
            cnt_d   = CNT_INIT;
            state_d = ST_COOLDOWN;
          end
        end
        default: state_d = ST_COOLDOWN;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_COOLDOWN;
      cnt_q     <= CNT_INIT;
      ptr_q     <= PTR_LAST;
      idx_q     <= '0;
      dead_q    <= '0;
      xi_q      <= '0;
      yi_q      <= '0;
      shooter_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      dead_q    <= dead_d;
      xi_q      <= xi_d;
      yi_q      <= yi_d;
      shooter_q <= shooter_d;
      none_q    <= none_d;
    end
  end

  assign disparar    = (state_q == ST_FIRE) && !pausa;
  assign xi_bola     = xi_q;
  assign yi_bola     = yi_q;
  assign atirador    = shooter_q;
  assign nenhum_vivo = none_q;

endmodule

// File: tb/tb_enemy_shot_scheduler.sv
// Directed bench for enemy_shot_scheduler with 4 enemies, 8-cycle cooldown.
// Shot table plus hand sequences for empty ring, pause, reset and restart.
module tb_enemy_shot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pausa;
  logic        rein;
  logic [3:0]  vivo;
  logic [39:0] xs;
  logic [39:0] ys;
  logic [9:0]  larg;
  logic [9:0]  alt;
  logic        bola;
  logic        disparar;
  logic [9:0]  xi_bola;
  logic [9:0]  yi_bola;
  logic [1:0]  atirador;
  logic        nenhum_vivo;

  int nvec = 0;
  int errs = 0;

  always #5 clk = ~clk;

  enemy_shot_scheduler #(
    .SIZE_ENEMY(4),
    .COOLDOWN_CYCLES(8)
  ) dut (
    .CLOCK_50(clk),
    .reset(rst_n),
    .pausa(pausa),
    .reiniciarJogo(rein),
    .vivo(vivo),
    .x_inimigo(xs),
    .y_inimigo(ys),
    .largura_inimigo(larg),
    .altura_inimigo(alt),
    .bola_ativa(bola),
    .disparar(disparar),
    .xi_bola(xi_bola),
    .yi_bola(yi_bola),
    .atirador(atirador),
    .nenhum_vivo(nenhum_vivo)
  );

  typedef struct {
    logic [3:0] vivo;
    int         wait_c;
    int         ati;
    int         xi;
    int         yi;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic fire_wait(input string nm, input int exp);
    int n;
    n = 0;
    while (disparar !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, exp);
  endtask

  task automatic after_fire(input string nm, input int ati,
                            input int xi, input int yi);
    @(negedge clk);
    chk({nm, "_single"}, int'(disparar), 0);
    chk({nm, "_ati"}, int'(atirador), ati);
    chk({nm, "_xi"}, int'(xi_bola), xi);
    chk({nm, "_yi"}, int'(yi_bola), yi);
    @(negedge clk);
    @(negedge clk);
    bola = 1'b1;
    @(negedge clk);
    bola = 1'b0;
  endtask

  initial begin
    int pulses;
    tbl[0] = '{4'b1111,  9, 0,   20, 116};
    tbl[1] = '{4'b1111, 10, 1,  210,  66};
    tbl[2] = '{4'b1111, 10, 2,  310, 166};
    tbl[3] = '{4'b1111, 10, 3, 1010,   7};
    tbl[4] = '{4'b1111, 10, 0,   20, 116};
    tbl[5] = '{4'b0100, 11, 2,  310, 166};
    tbl[6] = '{4'b0100, 13, 2,  310, 166};
    tbl[7] = '{4'b1001, 10, 3, 1010,   7};
    tbl[8] = '{4'b1001, 10, 0,   20, 116};
    tbl[9] = '{4'b1000, 12, 3, 1010,   7};

    rst_n = 1'b0;
    pausa = 1'b0;
    rein  = 1'b0;
    bola  = 1'b0;
    vivo  = 4'b1111;
    larg  = 10'd20;
    alt   = 10'd16;
    xs    = {10'd1000, 10'd300, 10'd200, 10'd10};
    ys    = {10'd1015, 10'd150, 10'd50, 10'd100};
    #1;
    chk("rst_disparar", int'(disparar), 0);
    chk("rst_xi", int'(xi_bola), 0);
    chk("rst_yi", int'(yi_bola), 0);
    chk("rst_ati", int'(atirador), 0);
    chk("rst_nv", int'(nenhum_vivo), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      vivo = tbl[i].vivo;
      fire_wait($sformatf("v%0d_wait", i), tbl[i].wait_c);
      chk($sformatf("v%0d_nv", i), int'(nenhum_vivo), 0);
      after_fire($sformatf("v%0d", i), tbl[i].ati, tbl[i].xi, tbl[i].yi);
    end

    // Empty ring: flag rises after the 4th dead test, ptr stays at 3.
    vivo = 4'b0000;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (disparar) pulses++;
    end
    chk("empty_nv_early", int'(nenhum_vivo), 0);
    @(negedge clk);
    chk("empty_nv_set", int'(nenhum_vivo), 1);
    repeat (12) begin
      @(negedge clk);
      if (disparar) pulses++;
    end
    chk("empty_no_fire", pulses, 0);
    chk("empty_nv_hold", int'(nenhum_vivo), 1);
    vivo = 4'b0001;
    fire_wait("revive_wait", 9);
    chk("revive_nv", int'(nenhum_vivo), 0);
    after_fire("revive", 0, 20, 116);

    // Pause mid-cooldown, then pause while in FIRE.
    vivo = 4'b0010;
    repeat (3) @(negedge clk);
    pausa = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (disparar) pulses++;
    end
    pausa = 1'b0;
    fire_wait("pause_cd_wait", 7);
    pausa = 1'b1;
    #1;
    chk("pause_fire_off", int'(disparar), 0);
    repeat (20) begin
      @(negedge clk);
      if (disparar) pulses++;
    end
    chk("pause_ati_hold", int'(atirador), 0);
    pausa = 1'b0;
    #1;
    chk("pause_release", int'(disparar), 1);
    pulses++;
    after_fire("pause", 1, 210, 66);
    chk("pause_pulses", pulses, 1);

    // Async reset while waiting for the ball to land, then wrapped X.
    vivo = 4'b1111;
    xs[9:0] = 10'd1020;
    fire_wait("wd_wait", 10);
    @(negedge clk);
    chk("wd_ati", int'(atirador), 2);
    @(negedge clk);
    @(negedge clk);
    bola = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("wd_rst_xi", int'(xi_bola), 0);
    chk("wd_rst_yi", int'(yi_bola), 0);
    chk("wd_rst_ati", int'(atirador), 0);
    chk("wd_rst_disp", int'(disparar), 0);
    bola = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fire_wait("wrap_wait", 9);
    after_fire("wrap", 0, 6, 116);

    // Synchronous restart wins over pause.
    repeat (3) @(negedge clk);
    pausa = 1'b1;
    rein  = 1'b1;
    @(negedge clk);
    chk("restart_xi", int'(xi_bola), 0);
    rein  = 1'b0;
    pausa = 1'b0;
    fire_wait("restart_wait", 9);
    after_fire("restart", 0, 6, 116);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end

endmodule
